instr_fetch_sequencer: RTL
==========================

// Module: instr_fetch_sequencer
// PURPOSE
//  Instruction source for the control decoder: holds the PC, reads a local instruction
//  memory and presents Instruction/Opcode (bits [6:0]) to the decoder each cycle.
//  Consumes the decoder's Branch output plus the ALU Zero flag to pick the next PC.
//  Halts on ECALL (32'h0000_0073) or on a misaligned branch target.
// PARAMETERS
//  IMEM_DEPTH  256           number of 32-bit words in instruction memory (power of 2)
//  RESET_PC    32'h0000_0000 PC value loaded on Reset (word aligned)
// PORTS
//  CLK           in   1   single clock, all state on rising edge
//  Reset         in   1   asynchronous, active-high reset
//  Branch        in   1   decoder branch strobe for the instruction currently presented
//  Zero          in   1   ALU zero flag for the instruction currently presented
//  BranchOffset  in   32  sign-extended byte offset, relative to current PC
//  Stall         in   1   1 = hold PC, Instruction, state
//  ImemWrEn      in   1   instruction-memory load strobe
//  ImemWrAddr    in   log2(IMEM_DEPTH)  word address for load
//  ImemWrData    in   32  word to load
//  PC            out  32  address of presented instruction
//  Instruction   out  32  registered instruction word at PC
//  Opcode        out  7   Instruction[6:0]
//  InstrValid    out  1   Instruction/Opcode are meaningful this cycle
//  Halted        out  1   ECALL reached or error; sticky until Reset
//  Error         out  1   misaligned branch target; sticky until Reset
// BEHAVIOUR
//  Reset (async, any time incl. mid-run): PC=RESET_PC, Instruction=0, Opcode=0,
//   InstrValid=0, Halted=0, Error=0, state=IDLE. Memory contents untouched.
//  States: IDLE -> RUN -> HALT.
//  IDLE: first edge after Reset deasserts: Instruction<=imem[RESET_PC>>2], InstrValid<=1,
//   PC unchanged, go RUN. Stall=1 holds IDLE.
//  RUN, Stall=0, each edge: next = (Branch&Zero) ? PC+BranchOffset : PC+4 (32-bit,
//   wraps mod 2^32). PC<=next; Instruction<=imem[next[31:2] mod IMEM_DEPTH] on same
//   edge, so PC and Instruction stay aligned; fetch latency 1 cycle after PC decision.
//  Branch with Zero=0 or Branch=0 -> sequential PC+4. Zero ignored when Branch=0.
//  Taken target with next[1:0]!=0: no PC update, Error<=1, Halted<=1, InstrValid<=0, HALT.
//  Presented Instruction==32'h0000_0073 in RUN (Stall=0): Halted<=1, InstrValid<=0,
//   PC/Instruction hold, HALT. Branch/Zero ignored that cycle.
//  RUN, Stall=1: all registers hold; Branch/Zero ignored.
//  HALT: absorbing; only Reset leaves. Stall irrelevant.
//  Imem load: write on edge when ImemWrEn=1, legal in any state. Same-edge write and
//   fetch of same word -> fetch returns OLD word (read-before-write).
//  Word index wraps modulo IMEM_DEPTH; PC itself keeps full 32 bits.
//  Opcode is always Instruction[6:0] (combinational from register).
// TESTING
//  1 Load 0x33,0x03,0x23 words at 0..2; release Reset -> edge1 PC=0 Opcode=51 Valid=1;
//    edge2 PC=4 Opcode=3; edge3 PC=8 Opcode=35.
//  2 At PC=8 drive Branch=1 Zero=1 Offset=-8 -> next edge PC=0, Instruction=imem[0];
//    repeat with Zero=0 -> PC=12.
//  3 Offset=6 with Branch=Zero=1 -> Error=1 Halted=1 InstrValid=0, PC stays; Stall
//    toggling afterward changes nothing.
//  4 Word 3 = 32'h0000_0073 -> at PC=12 next edge Halted=1 Valid=0 PC=12; async Reset
//    pulse mid-cycle -> outputs to reset values immediately, IDLE restart from 0.
//  5 Stall=1 for 3 edges at PC=4 -> PC/Instruction frozen; Branch=1 Zero=1 ignored.
//  6 IMEM_DEPTH=256, PC=0x3FC -> next PC=0x400, Instruction=imem[0] (index wrap);
//    same-edge ImemWrEn to that word -> old data fetched, new data on next revisit.

Source files
------------

// File: rtl/instr_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_sequencer_if
// Brief   : Decoder / ALU / loader bundle of the instruction fetch sequencer.
//           Signal suffixes name the direction as seen by the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface instr_fetch_sequencer_if #(
    parameter int IMEM_DEPTH = 256
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic          branch_i;
    logic          zero_i;
    logic [31:0]   branch_offset_i;
    logic          stall_i;
    logic          imem_wr_en_i;
    logic [AW-1:0] imem_wr_addr_i;
    logic [31:0]   imem_wr_data_i;
    logic [31:0]   pc_o;
    logic [31:0]   instruction_o;
    logic [6:0]    opcode_o;
    logic          instr_valid_o;
    logic          halted_o;
    logic          error_o;

    // Driver side: decoder, ALU and memory loader
    modport master (
        output branch_i, zero_i, branch_offset_i, stall_i,
               imem_wr_en_i, imem_wr_addr_i, imem_wr_data_i,
        input  pc_o, instruction_o, opcode_o, instr_valid_o, halted_o, error_o
    );

    // Sequencer side
    modport slave (
        input  branch_i, zero_i, branch_offset_i, stall_i,
               imem_wr_en_i, imem_wr_addr_i, imem_wr_data_i,
        output pc_o, instruction_o, opcode_o, instr_valid_o, halted_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_sequencer
// Brief   : Holds the PC, reads a local instruction memory and presents the
//           registered instruction to the decoder. Branch&Zero selects a
//           relative target; ECALL or a misaligned target halts the sequencer.
//           IMEM_DEPTH must match the parameter of the connected interface.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_sequencer #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    instr_fetch_sequencer_if.slave  bus
);
    localparam int          AW           = $clog2(IMEM_DEPTH);
    localparam logic [31:0] c_ECALL_WORD = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        error_q, error_d;

    logic [31:0] imem_q [IMEM_DEPTH];

    logic          w_taken;
    logic [31:0]   w_tgt_pc;
    logic [31:0]   w_next_pc;
    logic          w_misaligned;
    logic [AW-1:0] w_fetch_idx;
    logic [31:0]   w_fetch_word;

    // PC decision; the word index wraps while the PC keeps all 32 bits
    assign w_taken      = bus.branch_i & bus.zero_i;
    assign w_tgt_pc     = pc_q + bus.branch_offset_i;
    assign w_next_pc    = w_taken ? w_tgt_pc : (pc_q + 32'd4);
    assign w_misaligned = w_taken & (|w_tgt_pc[1:0]);
    assign w_fetch_idx  = (state_q == ST_IDLE) ? RESET_PC[AW+1:2] : w_next_pc[AW+1:2];
    // Combinational read of the pre-edge array gives read-before-write
    assign w_fetch_word = imem_q[w_fetch_idx];

    // Instruction memory load port; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.imem_wr_en_i) begin
            imem_q[bus.imem_wr_addr_i] <= bus.imem_wr_data_i;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic: IDLE primes the first fetch, RUN advances, HALT absorbs
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.stall_i) begin
                    instr_d = w_fetch_word;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall_i) begin
                    if (instr_q == c_ECALL_WORD) begin
                        // ECALL wins over any branch request this cycle
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                        state_d  = ST_HALT;
                    end else if (w_misaligned) begin
                        error_d  = 1'b1;
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d    = w_next_pc;
                        instr_d = w_fetch_word;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign bus.pc_o          = pc_q;
    assign bus.instruction_o = instr_q;
    assign bus.opcode_o      = instr_q[6:0];
    assign bus.instr_valid_o = valid_q;
    assign bus.halted_o      = halted_q;
    assign bus.error_o       = error_q;
endmodule
`default_nettype wire
